counter_cmd_arbiter: RTL

Shared-counter command scheduler for the counter sample designs. It collects UP/DOWN/CLEAR command pulses from up to `N_REQ` independent sources, such as host trigger-in bits, divided-clock autocount ticks and FPGA-side logic. It serialises those commands onto one `WIDTH`-bit counter with round-robin fairness and emits registered event pulses that are suitable for driving trigger-out endpoints. It sits between the endpoint/trigger layer and the counter value published on a wire-out.

---
 rtl/counter_cmd_arbiter_if.sv | 24 ++
 rtl/counter_cmd_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/counter_cmd_arbiter_if.sv
// Request-side bundle of the shared-counter command scheduler: per-requester
// strobes and commands in, pending status and grant pulses back.
interface counter_cmd_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [2*N_REQ-1:0] req_cmd;
  logic [N_REQ-1:0]   req_busy;
  logic [N_REQ-1:0]   grant;

  modport master (
    output req_valid,
    output req_cmd,
    input  req_busy,
    input  grant
  );

  modport slave (
    input  req_valid,
    input  req_cmd,
    output req_busy,
    output grant
  );
endinterface

// File: rtl/counter_cmd_arbiter.sv
// Round-robin scheduler serialising UP/DOWN/CLEAR commands from N_REQ sources
// onto one shared counter, with registered grant and event pulses.
module counter_cmd_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     cmp_value,
  input  logic                 ovf_clear,
  counter_cmd_arbiter_if.slave bus,
  output logic [WIDTH-1:0]     count,
  output logic                 evt_zero,
  output logic                 evt_cmp,
  output logic                 evt_wrap,
  output logic [N_REQ-1:0]     overflow
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    CmdNone  = 2'b00,
    CmdUp    = 2'b01,
    CmdDown  = 2'b10,
    CmdClear = 2'b11
  } cmd_e;

  cmd_e [N_REQ-1:0] slot_q, slot_d;
  logic [IdxW-1:0]  last_q, last_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ovf_q, ovf_d;
  logic             zero_q, zero_d, cmp_q, cmp_d, wrap_q, wrap_d;

  logic             gnt_found;
  logic [IdxW-1:0]  gnt_idx;
  int unsigned      arb_idx;
  cmd_e             cmd_sel;
  logic [WIDTH-1:0] result;
  logic             result_wrap;

  // Rotating-priority search starting just after the last winner.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = last_q;
    arb_idx   = 0;
    if (enable) begin
      for (int unsigned k = 1; k <= N_REQ; k++) begin
        arb_idx = (32'(last_q) + k) % N_REQ;
        if (!gnt_found && slot_q[arb_idx] != CmdNone) begin
          gnt_found = 1'b1;
          gnt_idx   = IdxW'(arb_idx);
        end
      end
    end
  end

  always_comb begin
    cmd_sel     = slot_q[gnt_idx];
    result      = count_q;
    result_wrap = 1'b0;
    case (cmd_sel)
      CmdUp: begin
        result      = count_q + WIDTH'(1);
        result_wrap = &count_q;
      end
      CmdDown: begin
        result      = count_q - WIDTH'(1);
        result_wrap = ~|count_q;
      end
      CmdClear: result = '0;
      default:  result = count_q;
    endcase
  end

  always_comb begin
    count_d = count_q;
    last_d  = last_q;
    grant_d = '0;
    zero_d  = 1'b0;
    cmp_d   = 1'b0;
    wrap_d  = 1'b0;
    if (gnt_found) begin
      count_d = result;
      last_d  = gnt_idx;
      grant_d = N_REQ'(1) << gnt_idx;
      zero_d  = (result == '0);
      cmp_d   = (result == cmp_value);
      wrap_d  = result_wrap;
    end
  end

  // A slot emptied by this edge's grant may be reloaded on the same edge.
  always_comb begin
    slot_d = slot_q;
    ovf_d  = ovf_clear ? '0 : ovf_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_d[i]) begin
        slot_d[i] = CmdNone;
      end
      if (bus.req_valid[i] && bus.req_cmd[2*i +: 2] != 2'b00) begin
        if (slot_d[i] == CmdNone) begin
          slot_d[i] = cmd_e'(bus.req_cmd[2*i +: 2]);
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      slot_q  <= {N_REQ{CmdNone}};
      last_q  <= IdxW'(N_REQ - 1);
      count_q <= '0;
      grant_q <= '0;
      ovf_q   <= '0;
      zero_q  <= 1'b0;
      cmp_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      last_q  <= last_d;
      count_q <= count_d;
      grant_q <= grant_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      cmp_q   <= cmp_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    bus.req_busy = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      bus.req_busy[i] = (slot_q[i] != CmdNone);
    end
  end

  assign bus.grant = grant_q;
  assign count     = count_q;
  assign evt_zero  = zero_q;
  assign evt_cmp   = cmp_q;
  assign evt_wrap  = wrap_q;
  assign overflow  = ovf_q;

endmodule
